// File: rtl/jb_to_af_conv.sv
// jb_to_af_conv
//   Converts one G1 Jacobian point whose coordinates are in Montgomery form
//   into the affine point in normal form:
//     A = mont(z,z) = z^2 R,  B = mont(A,z) = z^3 R
//     x_af = xM / A mod P,    y_af = yM / B mod P
//   The R factors cancel in the divisions, so no from-Montgomery multiply is
//   needed. The two Montgomery products use a shared external multiplier;
//   the two divisions use a local binary-Euclid inverter (one step per cycle)
//   guarded by a per-inversion watchdog.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pt/i_val/o_rdy        Jacobian point {z,y,x} input handshake
//   o_af/o_inf/o_err        affine result {y,x}, infinity flag, watchdog flag
//   o_val/i_rdy             result handshake
//   o_mul_a/o_mul_b/o_mul_val/i_mul_rdy   multiplier request
//   i_mul_res/i_mul_res_val               multiplier response
module jb_to_af_conv #(
  parameter int unsigned         DAT_BITS    = 256,
  parameter logic [DAT_BITS-1:0] P           = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter int unsigned         INV_MAX_CYC = 2048
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [3*DAT_BITS-1:0] i_pt,
  input  logic                  i_val,
  output logic                  o_rdy,
  output logic [2*DAT_BITS-1:0] o_af,
  output logic                  o_inf,
  output logic                  o_err,
  output logic                  o_val,
  input  logic                  i_rdy,
  output logic [DAT_BITS-1:0]   o_mul_a,
  output logic [DAT_BITS-1:0]   o_mul_b,
  output logic                  o_mul_val,
  input  logic                  i_mul_rdy,
  input  logic [DAT_BITS-1:0]   i_mul_res,
  input  logic                  i_mul_res_val
);

  localparam int unsigned         CW      = $clog2(INV_MAX_CYC + 1);
  localparam logic [DAT_BITS:0]   P_EXT   = {1'b0, P};
  localparam logic [DAT_BITS-1:0] ONE     = {{(DAT_BITS-1){1'b0}}, 1'b1};
  localparam logic [DAT_BITS-1:0] ZERO    = {DAT_BITS{1'b0}};
  localparam logic [CW-1:0]       CNT_MAX = CW'(INV_MAX_CYC);
  localparam logic [CW-1:0]       CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MZ2  = 3'd1,
    S_MZ3  = 3'd2,
    S_INVX = 3'd3,
    S_INVY = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  // x/2 mod P for x < P; adding P to an odd x makes the sum even and exact.
  function automatic logic [DAT_BITS:0] half_mod(input logic [DAT_BITS:0] x);
    logic [DAT_BITS:0] s;
    if (x[0]) begin
      s = x + P_EXT;
    end else begin
      s = x;
    end
    return s >> 1;
  endfunction

  // (a - b) mod P for a, b < P.
  function automatic logic [DAT_BITS:0] sub_mod(input logic [DAT_BITS:0] a,
                                                input logic [DAT_BITS:0] b);
    logic [DAT_BITS:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = a + P_EXT - b;
    end
    return r;
  endfunction

  state_t              state_r, state_nx_s;
  logic [DAT_BITS-1:0] x_m_r, y_m_r, z_m_r, b_r, x_af_r;
  logic [DAT_BITS-1:0] u_r, v_r, u_nx_s, v_nx_s;
  logic [DAT_BITS:0]   x1_r, x2_r, x1_nx_s, x2_nx_s;
  logic [CW-1:0]       cnt_r;
  logic [DAT_BITS-1:0] mul_a_r, mul_b_r;
  logic                mul_val_r, rdy_r, val_r, inf_r, err_r;
  logic [2*DAT_BITS-1:0] af_r;

  logic                inv_done_s, inv_tmo_s, inv_fin_s;
  logic [DAT_BITS-1:0] inv_val_s;
  logic                accept_s, z_zero_s;

  assign accept_s = (state_r == S_IDLE) && rdy_r && i_val;
  assign z_zero_s = (i_pt[3*DAT_BITS-1 -: DAT_BITS] == ZERO);

  assign o_rdy     = rdy_r;
  assign o_val     = val_r;
  assign o_af      = af_r;
  assign o_inf     = inf_r;
  assign o_err     = err_r;
  assign o_mul_a   = mul_a_r;
  assign o_mul_b   = mul_b_r;
  assign o_mul_val = mul_val_r;

  // One binary-Euclid step; invariants a*x1 = b*u and a*x2 = b*v (mod P).
  always_comb begin
    u_nx_s     = u_r;
    v_nx_s     = v_r;
    x1_nx_s    = x1_r;
    x2_nx_s    = x2_r;
    inv_done_s = (u_r == ONE) || (v_r == ONE);
    if (inv_done_s) begin
      u_nx_s = u_r;
    end else if (!u_r[0]) begin
      u_nx_s  = u_r >> 1;
      x1_nx_s = half_mod(x1_r);
    end else if (!v_r[0]) begin
      v_nx_s  = v_r >> 1;
      x2_nx_s = half_mod(x2_r);
    end else if (u_r >= v_r) begin
      u_nx_s  = u_r - v_r;
      x1_nx_s = sub_mod(x1_r, x2_r);
    end else begin
      v_nx_s  = v_r - u_r;
      x2_nx_s = sub_mod(x2_r, x1_r);
    end
  end

  // Inverter completion: normal finish wins over the watchdog; a timeout yields 0.
  always_comb begin
    inv_tmo_s = !inv_done_s && (cnt_r >= CNT_MAX);
    inv_fin_s = inv_done_s || inv_tmo_s;
    if (inv_tmo_s) begin
      inv_val_s = ZERO;
    end else if (u_r == ONE) begin
      inv_val_s = x1_r[DAT_BITS-1:0];
    end else begin
      inv_val_s = x2_r[DAT_BITS-1:0];
    end
  end

  // Next-state logic of the conversion sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx_s = z_zero_s ? S_OUT : S_MZ2;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_MZ2: begin
        if (i_mul_res_val) begin
          state_nx_s = S_MZ3;
        end else begin
          state_nx_s = S_MZ2;
        end
      end
      S_MZ3: begin
        if (i_mul_res_val) begin
          state_nx_s = S_INVX;
        end else begin
          state_nx_s = S_MZ3;
        end
      end
      S_INVX: begin
        if (inv_fin_s) begin
          state_nx_s = S_INVY;
        end else begin
          state_nx_s = S_INVX;
        end
      end
      S_INVY: begin
        if (inv_fin_s) begin
          state_nx_s = S_OUT;
        end else begin
          state_nx_s = S_INVY;
        end
      end
      S_OUT: begin
        if (i_rdy) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_OUT;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register plus handshake flags derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      rdy_r   <= 1'b0;
      val_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      rdy_r   <= (state_nx_s == S_IDLE);
      val_r   <= (state_nx_s == S_OUT);
    end
  end

  // Datapath: operand latching, multiplier requests, inverter and results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_m_r     <= ZERO;
      y_m_r     <= ZERO;
      z_m_r     <= ZERO;
      b_r       <= ZERO;
      x_af_r    <= ZERO;
      u_r       <= ZERO;
      v_r       <= ZERO;
      x1_r      <= {(DAT_BITS+1){1'b0}};
      x2_r      <= {(DAT_BITS+1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      mul_a_r   <= ZERO;
      mul_b_r   <= ZERO;
      mul_val_r <= 1'b0;
      inf_r     <= 1'b0;
      err_r     <= 1'b0;
      af_r      <= {(2*DAT_BITS){1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            x_m_r <= i_pt[DAT_BITS-1:0];
            y_m_r <= i_pt[2*DAT_BITS-1 -: DAT_BITS];
            z_m_r <= i_pt[3*DAT_BITS-1 -: DAT_BITS];
            err_r <= 1'b0;
            if (z_zero_s) begin
              inf_r <= 1'b1;
              af_r  <= {(2*DAT_BITS){1'b0}};
            end else begin
              inf_r     <= 1'b0;
              mul_a_r   <= i_pt[3*DAT_BITS-1 -: DAT_BITS];
              mul_b_r   <= i_pt[3*DAT_BITS-1 -: DAT_BITS];
              mul_val_r <= 1'b1;
            end
          end
        end
        S_MZ2: begin
          if (mul_val_r && i_mul_rdy) begin
            mul_val_r <= 1'b0;
          end
          // A is kept only in mul_a_r: it is the first operand of the next request
          // and the divisor of the x inversion.
          if (i_mul_res_val) begin
            mul_a_r   <= i_mul_res;
            mul_b_r   <= z_m_r;
            mul_val_r <= 1'b1;
          end
        end
        S_MZ3: begin
          if (mul_val_r && i_mul_rdy) begin
            mul_val_r <= 1'b0;
          end
          if (i_mul_res_val) begin
            b_r       <= i_mul_res;
            mul_val_r <= 1'b0;
            u_r       <= mul_a_r;
            v_r       <= P;
            x1_r      <= {1'b0, x_m_r};
            x2_r      <= {(DAT_BITS+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
          end
        end
        S_INVX: begin
          if (inv_fin_s) begin
            x_af_r <= inv_val_s;
            err_r  <= err_r | inv_tmo_s;
            u_r    <= b_r;
            v_r    <= P;
            x1_r   <= {1'b0, y_m_r};
            x2_r   <= {(DAT_BITS+1){1'b0}};
            cnt_r  <= {CW{1'b0}};
          end else begin
            u_r   <= u_nx_s;
            v_r   <= v_nx_s;
            x1_r  <= x1_nx_s;
            x2_r  <= x2_nx_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_INVY: begin
          if (inv_fin_s) begin
            af_r  <= {inv_val_s, x_af_r};
            err_r <= err_r | inv_tmo_s;
          end else begin
            u_r   <= u_nx_s;
            v_r   <= v_nx_s;
            x1_r  <= x1_nx_s;
            x2_r  <= x2_nx_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_OUT: begin
          af_r <= af_r;
        end
        default: begin
          mul_val_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jb_to_af_conv.sv
// Self-checking bench for jb_to_af_conv: directed points with known affine
// coordinates are lifted to Jacobian/Montgomery form; a behavioural
// Montgomery multiplier answers requests; a scoreboard checks each result.
`timescale 1ns/1ps
module tb_jb_to_af_conv;

  localparam int W  = 256;
  localparam int LM = 3;
  localparam logic [W-1:0] P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  logic           i_clk, i_rst_n;
  logic [3*W-1:0] i_pt;
  logic           i_val, o_rdy;
  logic [2*W-1:0] o_af;
  logic           o_inf, o_err, o_val, i_rdy;
  logic [W-1:0]   o_mul_a, o_mul_b, i_mul_res;
  logic           o_mul_val, i_mul_rdy, i_mul_res_val;

  typedef struct { logic [2*W-1:0] af; logic inf; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } mexp_t;

  exp_t  exp_q[$];
  mexp_t mexp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    res_cnt = 0;
  bit    mul_stall = 1'b0;

  jb_to_af_conv dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pt(i_pt), .i_val(i_val), .o_rdy(o_rdy),
    .o_af(o_af), .o_inf(o_inf), .o_err(o_err), .o_val(o_val), .i_rdy(i_rdy),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
    .i_mul_res(i_mul_res), .i_mul_res_val(i_mul_res_val)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- arithmetic reference ----------------
  function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    t = t % {{W{1'b0}}, P};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x);
    logic [2*W-1:0] t;
    t = {x, {W{1'b0}}};
    t = t % {{W{1'b0}}, P};
    return t[W-1:0];
  endfunction

  // Bit-serial Montgomery product a*b*2^-256 mod P.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, P};
      t = t >> 1;
    end
    if (t >= {2'b00, P}) t = t - {2'b00, P};
    return t[W-1:0];
  endfunction

  // Jacobian (x z^2, y z^3, z) of affine (x, y), all in Montgomery form, packed {z,y,x}.
  function automatic logic [3*W-1:0] build(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] z);
    logic [W-1:0] z2, z3;
    z2 = modmul(z, z);
    z3 = modmul(z2, z);
    return {to_mont(z), to_mont(modmul(y, z3)), to_mont(modmul(x, z2))};
  endfunction

  function automatic logic [W-1:0] rnd_fe();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
    r = r % P;
    return r;
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- output scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_val && i_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", o_af);
        end else begin
          e = exp_q.pop_front();
          chk("af", o_af, e.af);
          chk("inf", {511'd0, o_inf}, {511'd0, e.inf});
          chk("err", {511'd0, o_err}, 512'd0);
        end
      end
    end
  end

  // ---------------- behavioural Montgomery multiplier ----------------
  initial begin
    int           pend, stall_left;
    bit           acc;
    logic [W-1:0] pres;
    mexp_t        m;
    pend = 0; stall_left = 0; acc = 1'b0; pres = '0;
    i_mul_rdy = 1'b0; i_mul_res_val = 1'b0; i_mul_res = '0;
    forever begin
      @(posedge i_clk); #1;
      i_mul_res_val = 1'b0;
      if (!i_rst_n) begin
        pend = 0; acc = 1'b0; i_mul_rdy = 1'b0;
      end else begin
        if (acc) begin
          if (mexp_q.size() > 0) begin
            m = mexp_q.pop_front();
            pres = mont(m.a, m.b);
            pend = LM;
          end
          acc = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            i_mul_res_val = 1'b1;
            i_mul_res = pres;
            res_cnt++;
          end
        end
        if (o_mul_val) begin
          if (mexp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_mul_req actual=1 required=0");
          end else begin
            chk("mul_a", {256'd0, o_mul_a}, {256'd0, mexp_q[0].a});
            chk("mul_b", {256'd0, o_mul_b}, {256'd0, mexp_q[0].b});
            chk("rdy_busy", {511'd0, o_rdy}, 512'd0);
          end
          if (stall_left > 0) begin
            stall_left--;
            i_mul_rdy = 1'b0;
          end else begin
            i_mul_rdy = 1'b1;
          end
          acc = i_mul_rdy;
        end else begin
          i_mul_rdy = 1'b0;
          stall_left = mul_stall ? 5 : 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_mul(input logic [3*W-1:0] pt);
    logic [W-1:0] zm;
    zm = pt[3*W-1 -: W];
    if (zm != '0) begin
      mexp_q.push_back('{a: zm, b: zm});
      mexp_q.push_back('{a: mont(zm, zm), b: zm});
    end
  endtask

  task automatic send(input logic [3*W-1:0] pt);
    int n;
    n = 0;
    i_pt = pt;
    i_val = 1'b1;
    @(negedge i_clk);
    while (!o_rdy && n < 6000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<6000", n);
    end
    @(posedge i_clk); #1;
    i_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout actual=%0d required=<6000", n);
      exp_q.delete();
    end
    @(posedge i_clk); #1;
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                     input bit out_stall);
    logic [3*W-1:0] pt;
    int n;
    pt = build(x, y, z);
    push_mul(pt);
    exp_q.push_back('{af: {y, x}, inf: 1'b0});
    if (out_stall) i_rdy = 1'b0;
    send(pt);
    if (out_stall) begin
      n = 0;
      while (!o_val && n < 6000) begin
        @(negedge i_clk);
        n++;
      end
      for (int k = 0; k < 10; k++) begin
        @(negedge i_clk);
        chk("hold_val", {511'd0, o_val}, 512'd1);
        chk("hold_af", o_af, {y, x});
        chk("hold_rdy", {511'd0, o_rdy}, 512'd0);
      end
      @(posedge i_clk); #1;
      i_rdy = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    logic [3*W-1:0] pt;
    logic [W-1:0]   rx, ry, rz;
    int             base, n;
    i_val = 1'b0; i_pt = '0; i_rdy = 1'b1; i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_rdy", {511'd0, o_rdy}, 512'd0);
    chk("rst_val", {511'd0, o_val}, 512'd0);
    chk("rst_inf", {511'd0, o_inf}, 512'd0);
    chk("rst_err", {511'd0, o_err}, 512'd0);
    chk("rst_mul_val", {511'd0, o_mul_val}, 512'd0);
    chk("rst_af", o_af, 512'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("rdy_after_rst", {511'd0, o_rdy}, 512'd1);

    // Generator (1,2) with z = 1, 2, P-1.
    run(256'd1, 256'd2, 256'd1, 1'b0);
    run(256'd1, 256'd2, 256'd2, 1'b0);
    run(256'd1, 256'd2, P - 256'd1, 1'b0);

    // z = 0: point at infinity, no multiplier traffic.
    pt = {256'd0, to_mont(256'd7), to_mont(256'd5)};
    exp_q.push_back('{af: 512'd0, inf: 1'b1});
    send(pt);
    wait_drain();

    // Field boundaries in the coordinates.
    run(P - 256'd1, 256'd0, 256'd3, 1'b0);
    run(256'd0, P - 256'd1, 256'd5, 1'b0);

    // Arbitrary coordinates with arbitrary non-zero z.
    for (int i = 0; i < 3; i++) begin
      rx = rnd_fe(); ry = rnd_fe(); rz = rnd_fe();
      if (rz == '0) rz = 256'd1;
      run(rx, ry, rz, 1'b0);
    end

    // Back-pressure on both the multiplier and the result port.
    mul_stall = 1'b1;
    run(256'd12345, 256'd67890, 256'd7, 1'b1);
    mul_stall = 1'b0;

    // Reset during the x inversion: old point must vanish.
    base = res_cnt;
    pt = build(256'd99, 256'd101, 256'd13);
    push_mul(pt);
    send(pt);
    n = 0;
    while (res_cnt < base + 2 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("mul_results_before_rst", 512'(res_cnt - base), 512'd2);
    repeat (20) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_rdy", {511'd0, o_rdy}, 512'd0);
    chk("midrst_val", {511'd0, o_val}, 512'd0);
    chk("midrst_inf", {511'd0, o_inf}, 512'd0);
    chk("midrst_err", {511'd0, o_err}, 512'd0);
    chk("midrst_mul_val", {511'd0, o_mul_val}, 512'd0);
    chk("midrst_af", o_af, 512'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    mexp_q.delete();
    @(posedge i_clk); #1;
    run(256'd3, 256'd4, 256'd11, 1'b0);
    repeat (20) @(posedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
